sha2_msg_sched_stream: RTL

//   Streaming SHA-2 message scheduler, generalised over word width and round count.

---
 rtl/sha2_msg_sched_stream.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sha2_msg_sched_stream.sv
// rtl/sha2_msg_sched_stream.sv - streaming SHA-256/SHA-512 message scheduler emitting W[0..ROUNDS-1]
// Build macro MSG_SCHED_BSWAP_EN: byte-reverse each input word (little-endian host bus).
module sha2_msg_sched_stream #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              blk_start_i,
   input  logic              abort_i,
   input  logic              m_valid_i,
   output logic              m_ready_o,
   input  logic [WORD_W-1:0] m_data_i,
   output logic              w_valid_o,
   input  logic              w_ready_i,
   output logic [WORD_W-1:0] w_data_o,
   output logic [6:0]        w_round_o,
   output logic              w_last_o,
   output logic              busy_o,
   output logic              done_o
);

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("sha2_msg_sched_stream: WORD_W must be 32 or 64");
   end
   if (ROUNDS < 17 || ROUNDS > 127) begin : g_bad_rounds
      $error("sha2_msg_sched_stream: ROUNDS must be 17..127");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [6:0] LAST_T  = 7'(ROUNDS - 1);

   // Rotate/shift amounts of the small sigma functions for the selected width.
   localparam int S0_A = (WORD_W == 32) ? 7  : 1;
   localparam int S0_B = (WORD_W == 32) ? 18 : 8;
   localparam int S0_C = (WORD_W == 32) ? 3  : 7;
   localparam int S1_A = (WORD_W == 32) ? 17 : 19;
   localparam int S1_B = (WORD_W == 32) ? 19 : 61;
   localparam int S1_C = (WORD_W == 32) ? 10 : 6;

   logic [1:0]        state_q, state_d;
   logic [6:0]        cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [WORD_W-1:0] win_q [16];
   logic [WORD_W-1:0] win_d [16];
   logic [WORD_W-1:0] m_word;
   logic [WORD_W-1:0] nxt;
   logic              run;
   logic              m_acc;
   logic              w_acc;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
   endfunction

   always_comb begin
      m_word = m_data_i;
`ifdef MSG_SCHED_BSWAP_EN
      for (int b = 0; b < WORD_W / 8; b++) begin
         m_word[8*b +: 8] = m_data_i[WORD_W-8-8*b +: 8];
      end
`endif
   end

   // The window always holds W[t-16..t-1] once t>=16, so nxt is W[t].
   assign nxt       = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
   assign run       = (state_q == ST_RUN);
   assign m_ready_o = (state_q == ST_LOAD);
   assign w_valid_o = run;
   assign w_data_o  = !run ? '0 : ((cnt_q < 7'd16) ? win_q[cnt_q[3:0]] : nxt);
   assign w_round_o = run ? cnt_q : 7'd0;
   assign w_last_o  = run && (cnt_q == LAST_T);
   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = done_q;
   assign m_acc     = m_ready_o && m_valid_i;
   assign w_acc     = run && w_ready_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         win_d[i] = win_q[i];
      end
      if (abort_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (blk_start_i) begin
                  state_d = ST_LOAD;
                  cnt_d   = '0;
               end
            end
            ST_LOAD: begin
               if (m_acc) begin
                  win_d[cnt_q[3:0]] = m_word;
                  if (cnt_q == 7'd15) begin
                     state_d = ST_RUN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
            end
            ST_RUN: begin
               if (w_acc) begin
                  if (cnt_q >= 7'd16) begin
                     for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                     end
                     win_d[15] = nxt;
                  end
                  if (w_last_o) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

endmodule
